// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared addresses, CTRL bit indices and state encoding for the fade sequencer
package pwm_fade_pkg;
  localparam logic [11:0] PWM_ADDR_DEF = 12'h200;
  localparam logic [11:0] BASE_ADDR_DEF = 12'h210;
  localparam logic [11:0] TARGET_OFS = 12'h000;
  localparam logic [11:0] STEP_OFS = 12'h004;
  localparam logic [11:0] INTERVAL_OFS = 12'h008;
  localparam logic [11:0] CTRL_OFS = 12'h00C;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;
endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// pwm_fade_ctrl_if: CPU-side bus, PWM-side write port and status lines of the fade sequencer
interface pwm_fade_ctrl_if;
  logic        CS_N;
  logic        RD_N;
  logic        WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        pwm_cs_n;
  logic        pwm_wr_n;
  logic [11:0] pwm_addr;
  logic [7:0]  pwm_data;
  logic        busy;
  logic        done_irq;
  modport master (
    output CS_N, RD_N, WR_N, Addr, DataIn,
    input  DataOut, pwm_cs_n, pwm_wr_n, pwm_addr, pwm_data, busy, done_irq
  );
  modport slave (
    input  CS_N, RD_N, WR_N, Addr, DataIn,
    output DataOut, pwm_cs_n, pwm_wr_n, pwm_addr, pwm_data, busy, done_irq
  );
endinterface

// File: rtl/fade_interval_timer.sv
// fade_interval_timer: loadable down-counter, a load of 0 counts as 1, expire when the count reaches 1
module fade_interval_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = load ? ((load_val == '0) ? W'(1) : load_val)
                           : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = cnt_q == W'(1);
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: steps the PWM duty register toward a target, one bus write per interval,
// and passes direct CPU duty writes through to the PWM when they occur.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter logic [11:0] PWM_ADDR   = PWM_ADDR_DEF,
  parameter logic [11:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int          INTERVAL_W = 16
) (
  input logic            clk,
  input logic            reset,
  pwm_fade_ctrl_if.slave bus
);
  state_t state_d, state_q;
  logic [7:0] cur_d, cur_q, target_d, target_q, step_d, step_q, pdata_d, pdata_q, nxt;
  logic [INTERVAL_W-1:0] interval_d, interval_q;
  logic [11:0] paddr_d, paddr_q;
  logic [8:0] sum, diff;
  logic done_d, done_q, busy, cpu_wr, cpu_rd, wr_pwm, wr_tgt, wr_step, wr_int, wr_ctrl;
  logic start, abort, load, strobe, expire, up;
  assign cpu_wr  = !bus.CS_N && !bus.WR_N;
  assign cpu_rd  = !bus.CS_N && !bus.RD_N;
  assign wr_pwm  = cpu_wr && bus.Addr == PWM_ADDR;
  assign wr_tgt  = cpu_wr && bus.Addr == BASE_ADDR + TARGET_OFS;
  assign wr_step = cpu_wr && bus.Addr == BASE_ADDR + STEP_OFS;
  assign wr_int  = cpu_wr && bus.Addr == BASE_ADDR + INTERVAL_OFS;
  assign wr_ctrl = cpu_wr && bus.Addr == BASE_ADDR + CTRL_OFS;
  assign start   = wr_ctrl && bus.DataIn[CTRL_START];
  assign abort   = wr_ctrl && bus.DataIn[CTRL_ABORT];
  assign busy    = state_q != IDLE;
  // 9-bit sum/difference so the clamp to target catches wrap in either direction
  assign sum  = {1'b0, cur_q} + {1'b0, step_q};
  assign diff = {1'b0, cur_q} - {1'b0, step_q};
  assign up   = target_q > cur_q;
  assign nxt  = (step_q == '0) ? target_q
              : up ? ((sum >= {1'b0, target_q}) ? target_q : sum[7:0])
              : ((diff[8] || diff[7:0] <= target_q) ? target_q : diff[7:0]);
  fade_interval_timer #(.W(INTERVAL_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dec      (state_q == WAIT),
    .load_val (interval_q),
    .expire   (expire)
  );
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    done_d     = done_q;
    load       = 1'b0;
    strobe     = 1'b0;
    target_d   = wr_tgt ? bus.DataIn[7:0] : target_q;
    step_d     = wr_step ? bus.DataIn[7:0] : step_q;
    interval_d = wr_int ? bus.DataIn[INTERVAL_W-1:0] : interval_q;
    if (wr_pwm) begin
      cur_d   = bus.DataIn[7:0];
      done_d  = 1'b0;
      state_d = IDLE;
    end else if (abort) begin
      state_d = IDLE;
    end else if (start) begin
      done_d  = cur_q == target_q;
      load    = cur_q != target_q;
      state_d = (cur_q == target_q) ? IDLE : WAIT;
    end else begin
      case (state_q)
        WAIT: state_d = expire ? WRITE : WAIT;
        WRITE: begin
          strobe  = 1'b1;
          cur_d   = nxt;
          done_d  = nxt == target_q;
          load    = nxt != target_q;
          state_d = (nxt == target_q) ? IDLE : WAIT;
        end
        default: ;
      endcase
    end
    paddr_d = wr_pwm ? bus.Addr : strobe ? PWM_ADDR : paddr_q;
    pdata_d = wr_pwm ? bus.DataIn[7:0] : strobe ? nxt : pdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      done_q     <= 1'b0;
      paddr_q    <= '0;
      pdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      done_q     <= done_d;
      paddr_q    <= paddr_d;
      pdata_q    <= pdata_d;
    end
  end
  assign bus.pwm_cs_n = !(wr_pwm || strobe);
  assign bus.pwm_wr_n = !(wr_pwm || strobe);
  assign bus.pwm_addr = paddr_d;
  assign bus.pwm_data = pdata_d;
  assign bus.busy     = busy;
  assign bus.done_irq = done_q;
  assign bus.DataOut  = !cpu_rd ? 32'd0
                      : (bus.Addr == PWM_ADDR) ? 32'(cur_q)
                      : (bus.Addr == BASE_ADDR + TARGET_OFS) ? 32'(target_q)
                      : (bus.Addr == BASE_ADDR + STEP_OFS) ? 32'(step_q)
                      : (bus.Addr == BASE_ADDR + INTERVAL_OFS) ? 32'(interval_q)
                      : (bus.Addr == BASE_ADDR + CTRL_OFS) ? 32'({done_q, busy})
                      : 32'd0;
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed scenarios for the fade sequencer with hand-computed strobe data and timing
module tb_pwm_fade_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wcyc = 0;
  logic [7:0] logd[$];
  int logc[$];
  logic [11:0] loga[$];
  logic [31:0] rdata;
  pwm_fade_ctrl_if bus();
  pwm_fade_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!bus.pwm_cs_n && !bus.pwm_wr_n) begin
      logd.push_back(bus.pwm_data);
      logc.push_back(cyc);
      loga.push_back(bus.pwm_addr);
    end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic clr_log();
    logd.delete();
    logc.delete();
    loga.delete();
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.CS_N = 1'b0;
    bus.WR_N = 1'b0;
    bus.Addr = a;
    bus.DataIn = d;
    @(posedge clk);
    #1;
    wcyc = cyc;
    bus.CS_N = 1'b1;
    bus.WR_N = 1'b1;
  endtask
  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.CS_N = 1'b0;
    bus.RD_N = 1'b0;
    bus.Addr = a;
    #1;
    d = bus.DataOut;
    bus.CS_N = 1'b1;
    bus.RD_N = 1'b1;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) begin $display("FAIL %s idle timeout busy=%0b want 0", nm, bus.busy); bad++; end
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) begin $display("FAIL rst_busy got=%0b want 0", bus.busy); bad++; end
    total++; if (bus.done_irq !== 1'b0) begin $display("FAIL rst_done got=%0b want 0", bus.done_irq); bad++; end
    total++; if (bus.pwm_cs_n !== 1'b1 || bus.pwm_wr_n !== 1'b1) begin $display("FAIL rst_pwm_strb got=%0b%0b want 11", bus.pwm_cs_n, bus.pwm_wr_n); bad++; end
    total++; if (bus.pwm_addr !== 12'h0 || bus.pwm_data !== 8'h0) begin $display("FAIL rst_pwm_bus got=%h/%h want 000/00", bus.pwm_addr, bus.pwm_data); bad++; end
    total++; if (bus.DataOut !== 32'h0) begin $display("FAIL rst_dout_nosel got=%h want 0", bus.DataOut); bad++; end
    rd(12'h21C, rdata);
    total++; if (rdata !== 32'h0) begin $display("FAIL rst_status got=%h want 0", rdata); bad++; end
    rd(12'h200, rdata);
    total++; if (rdata !== 32'h0) begin $display("FAIL rst_cur got=%h want 0", rdata); bad++; end
  endtask
  task automatic test_reset_mid_wait();
    clr_log();
    wr(12'h210, 32'd50);
    wr(12'h214, 32'd1);
    wr(12'h218, 32'd10);
    wr(12'h21C, 32'h1);
    repeat (3) @(posedge clk);
    #2;
    total++; if (bus.busy !== 1'b1) begin $display("FAIL mid_busy_before got=%0b want 1", bus.busy); bad++; end
    reset = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) begin $display("FAIL mid_busy got=%0b want 0", bus.busy); bad++; end
    total++; if (bus.pwm_cs_n !== 1'b1) begin $display("FAIL mid_cs_n got=%0b want 1", bus.pwm_cs_n); bad++; end
    total++; if (bus.done_irq !== 1'b0) begin $display("FAIL mid_done got=%0b want 0", bus.done_irq); bad++; end
    rd(12'h210, rdata);
    total++; if (rdata !== 32'h0) begin $display("FAIL mid_target got=%h want 0", rdata); bad++; end
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (logd.size() !== 0) begin $display("FAIL mid_strobes got=%0d want 0", logd.size()); bad++; end
  endtask
  task automatic test_fade_up();
    int s;
    clr_log();
    wr(12'h210, 32'd10);
    wr(12'h214, 32'd4);
    wr(12'h218, 32'd3);
    wr(12'h21C, 32'h1);
    s = wcyc;
    wait_idle("up");
    total++; if (logd.size() !== 3) begin $display("FAIL up_count got=%0d want 3", logd.size()); bad++; end
    if (logd.size() == 3) begin
      total++; if (logd[0] !== 8'd4 || logd[1] !== 8'd8 || logd[2] !== 8'd10) begin $display("FAIL up_data got=%0d,%0d,%0d want 4,8,10", logd[0], logd[1], logd[2]); bad++; end
      total++; if (logc[0] !== s + 3) begin $display("FAIL up_first_lat got=%0d want %0d", logc[0] - s, 3); bad++; end
      total++; if (logc[1] - logc[0] !== 4 || logc[2] - logc[1] !== 4) begin $display("FAIL up_spacing got=%0d,%0d want 4,4", logc[1] - logc[0], logc[2] - logc[1]); bad++; end
      total++; if (loga[0] !== 12'h200) begin $display("FAIL up_addr got=%h want 200", loga[0]); bad++; end
    end
    total++; if (bus.done_irq !== 1'b1) begin $display("FAIL up_done got=%0b want 1", bus.done_irq); bad++; end
    rd(12'h21C, rdata);
    total++; if (rdata !== 32'h2) begin $display("FAIL up_status got=%h want 2", rdata); bad++; end
    rd(12'h200, rdata);
    total++; if (rdata !== 32'd10) begin $display("FAIL up_cur got=%0d want 10", rdata); bad++; end
  endtask
  task automatic test_jump_down();
    int s;
    wr(12'h200, 32'd200);
    clr_log();
    wr(12'h210, 32'd5);
    wr(12'h214, 32'd0);
    wr(12'h218, 32'd0);
    wr(12'h21C, 32'h1);
    s = wcyc;
    wait_idle("jump");
    total++; if (logd.size() !== 1) begin $display("FAIL jump_count got=%0d want 1", logd.size()); bad++; end
    if (logd.size() == 1) begin
      total++; if (logd[0] !== 8'd5) begin $display("FAIL jump_data got=%0d want 5", logd[0]); bad++; end
      total++; if (logc[0] !== s + 1) begin $display("FAIL jump_lat got=%0d want 1", logc[0] - s); bad++; end
    end
    total++; if (bus.done_irq !== 1'b1) begin $display("FAIL jump_done got=%0b want 1", bus.done_irq); bad++; end
    rd(12'h200, rdata);
    total++; if (rdata !== 32'd5) begin $display("FAIL jump_cur got=%0d want 5", rdata); bad++; end
  endtask
  task automatic test_fade_down();
    int s;
    wr(12'h200, 32'd10);
    clr_log();
    wr(12'h210, 32'd3);
    wr(12'h214, 32'd4);
    wr(12'h218, 32'd1);
    wr(12'h21C, 32'h1);
    s = wcyc;
    wait_idle("down");
    total++; if (logd.size() !== 2) begin $display("FAIL down_count got=%0d want 2", logd.size()); bad++; end
    if (logd.size() == 2) begin
      total++; if (logd[0] !== 8'd6 || logd[1] !== 8'd3) begin $display("FAIL down_data got=%0d,%0d want 6,3", logd[0], logd[1]); bad++; end
      total++; if (logc[0] !== s + 1 || logc[1] - logc[0] !== 2) begin $display("FAIL down_timing got=%0d,%0d want 1,2", logc[0] - s, logc[1] - logc[0]); bad++; end
    end
  endtask
  task automatic test_no_move();
    wr(12'h200, 32'd0);
    total++; if (bus.done_irq !== 1'b0) begin $display("FAIL nomove_done_clr got=%0b want 0", bus.done_irq); bad++; end
    clr_log();
    wr(12'h210, 32'd0);
    wr(12'h21C, 32'h1);
    total++; if (bus.done_irq !== 1'b1 || bus.busy !== 1'b0) begin $display("FAIL nomove_flags got=done%0b busy%0b want done1 busy0", bus.done_irq, bus.busy); bad++; end
    repeat (6) @(posedge clk);
    #1;
    total++; if (logd.size() !== 0) begin $display("FAIL nomove_strobes got=%0d want 0", logd.size()); bad++; end
  endtask
  task automatic test_collision();
    int n = 0;
    wr(12'h200, 32'd0);
    wr(12'h210, 32'd255);
    wr(12'h214, 32'd1);
    wr(12'h218, 32'd2);
    wr(12'h21C, 32'h1);
    clr_log();
    while (bus.pwm_cs_n && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (bus.pwm_cs_n !== 1'b0) begin $display("FAIL coll_strobe_timeout cs_n=%0b want 0", bus.pwm_cs_n); bad++; end
    total++; if (bus.pwm_data !== 8'd1) begin $display("FAIL coll_engine_data got=%0d want 1", bus.pwm_data); bad++; end
    clr_log();
    bus.CS_N = 1'b0;
    bus.WR_N = 1'b0;
    bus.Addr = 12'h200;
    bus.DataIn = 32'h80;
    #1;
    total++; if (bus.pwm_data !== 8'h80 || bus.pwm_addr !== 12'h200 || bus.pwm_cs_n !== 1'b0) begin $display("FAIL coll_fwd got=%h/%h cs%0b want 200/80 cs0", bus.pwm_addr, bus.pwm_data, bus.pwm_cs_n); bad++; end
    @(posedge clk);
    #1;
    bus.CS_N = 1'b1;
    bus.WR_N = 1'b1;
    total++; if (bus.busy !== 1'b0 || bus.done_irq !== 1'b0) begin $display("FAIL coll_flags got=busy%0b done%0b want busy0 done0", bus.busy, bus.done_irq); bad++; end
    rd(12'h200, rdata);
    total++; if (rdata !== 32'h80) begin $display("FAIL coll_cur got=%h want 80", rdata); bad++; end
    repeat (10) @(posedge clk);
    #1;
    total++; if (logd.size() !== 1) begin $display("FAIL coll_strobes got=%0d want 1", logd.size()); bad++; end
    if (logd.size() == 1) begin
      total++; if (logd[0] !== 8'h80) begin $display("FAIL coll_logdata got=%h want 80", logd[0]); bad++; end
    end
  endtask
  task automatic test_abort();
    int n = 0;
    wr(12'h200, 32'd0);
    wr(12'h210, 32'd20);
    wr(12'h214, 32'd4);
    wr(12'h218, 32'd5);
    clr_log();
    wr(12'h21C, 32'h1);
    while (logd.size() < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (logd.size() !== 2) begin $display("FAIL abort_pre_count got=%0d want 2", logd.size()); bad++; end
    wr(12'h21C, 32'h2);
    total++; if (bus.busy !== 1'b0) begin $display("FAIL abort_busy got=%0b want 0", bus.busy); bad++; end
    repeat (20) @(posedge clk);
    #1;
    total++; if (logd.size() !== 2) begin $display("FAIL abort_strobes got=%0d want 2", logd.size()); bad++; end
    rd(12'h200, rdata);
    total++; if (rdata !== 32'd8) begin $display("FAIL abort_cur got=%0d want 8", rdata); bad++; end
    total++; if (bus.done_irq !== 1'b0) begin $display("FAIL abort_done got=%0b want 0", bus.done_irq); bad++; end
    wr(12'h210, 32'd12);
    wr(12'h21C, 32'h1);
    wait_idle("restart");
    total++; if (logd.size() !== 3) begin $display("FAIL restart_count got=%0d want 3", logd.size()); bad++; end
    if (logd.size() == 3) begin
      total++; if (logd[2] !== 8'd12) begin $display("FAIL restart_data got=%0d want 12", logd[2]); bad++; end
    end
    total++; if (bus.done_irq !== 1'b1) begin $display("FAIL restart_done got=%0b want 1", bus.done_irq); bad++; end
  endtask
  initial begin
    bus.CS_N = 1'b1;
    bus.RD_N = 1'b1;
    bus.WR_N = 1'b1;
    bus.Addr = 12'h0;
    bus.DataIn = 32'h0;
    test_reset();
    test_reset_mid_wait();
    test_fade_up();
    test_jump_down();
    test_fade_down();
    test_no_move();
    test_collision();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Memory-mapped fade sequencer placed between the CPU I/O bus and the PWM peripheral's write port. The CPU programs a target duty, step size and step interval, then issues a start command. The block steps the PWM duty register (0x200) toward the target, one bus write per interval. When the engine is idle or aborted, direct CPU writes to 0x200 pass through to the PWM.

Parameters:
PWM_ADDR, 12'h200, address of the PWM duty register on the PWM-side bus.
BASE_ADDR, 12'h210, base address of this block's registers.
INTERVAL_W, 16, width of the step interval counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
CS_N  in  1  CPU chip select, active low
RD_N  in  1  CPU read strobe, active low
WR_N  in  1  CPU write strobe, active low
Addr  in  12  CPU address
DataIn  in  32  CPU write data
DataOut  out  32  read data, combinational
pwm_cs_n  out  1  PWM-side chip select, active low
pwm_wr_n  out  1  PWM-side write strobe, active low
pwm_addr  out  12  PWM-side address
pwm_data  out  8  PWM-side write data
busy  out  1  engine active
done_irq  out  1  sticky fade-complete flag

Behaviour:
- Clock is clk; reset is asynchronous, active-high. Reset clears all registers: cur_duty=0 (matches PWM reset), target=0, step=0, interval=0, state IDLE, done=0. Reset also drives pwm_cs_n=1, pwm_wr_n=1, pwm_addr=0 and pwm_data=0.
- Register map (CPU write when CS_N=0 and WR_N=0, sampled on the posedge):
  - 0x210 TARGET[7:0].
  - 0x214 STEP[7:0].
  - 0x218 INTERVAL[15:0].
  - 0x21C CTRL: bit0 = start (self-clearing); bit1 = abort.
- Reads (CS_N=0, RD_N=0) are combinational and zero-extended. DataOut=0 otherwise.
  - 0x200 returns cur_duty.
  - 0x210, 0x214 and 0x218 return the stored values.
  - 0x21C returns STATUS = {done, busy} in bits [1:0].
- States: IDLE, WAIT, WRITE.
  - IDLE + start: clear done.
    - If cur_duty==target, set done and stay IDLE with no PWM write.
    - Otherwise load cnt=max(interval,1) and go to WAIT.
  - WAIT: decrement cnt each cycle; move to WRITE when cnt==1. WAIT therefore lasts max(interval,1) cycles.
  - WRITE (exactly 1 cycle): drive pwm_cs_n=0, pwm_wr_n=0, pwm_addr=PWM_ADDR, pwm_data=next. At the posedge, cur_duty<=next.
    - If next==target, set done and go to IDLE.
    - Otherwise reload cnt and go to WAIT.
  - Successive strobes are spaced interval+1 cycles apart.
- next computation uses 9-bit arithmetic and never overshoots:
  - Up: next = min(cur+step, target).
  - Down: next = max(cur-step, target).
  - step==0 is treated as a jump: next = target.
- busy = (state != IDLE).
- Abort (CTRL bit1) in any state goes to IDLE. done is not set, cur_duty is unchanged and no strobe is issued in that cycle.
- Start while busy restarts from the current cur_duty with the current registers.
- TARGET, STEP or INTERVAL writes while busy are legal. TARGET and STEP take effect at the next WRITE; INTERVAL takes effect at the next reload.
- CPU write to 0x200: forwarded combinationally in the same cycle (pwm_cs_n=CS_N, pwm_wr_n=WR_N, pwm_addr=Addr, pwm_data=DataIn[7:0]). It also sets cur_duty<=DataIn[7:0] and aborts the engine, which clears done.
- Collision rule: a CPU 0x200 write during WRITE wins, and the engine strobe is suppressed.
- Outside WRITE and outside CPU 0x200 writes, the PWM-side bus is idle: cs_n=1 and wr_n=1, with addr/data holding the last driven value.

Decomposition:
- Package pwm_fade_pkg holds:
  - address constants (PWM_ADDR, TARGET/STEP/INTERVAL/CTRL offsets);
  - the state encoding enum {IDLE, WAIT, WRITE};
  - CTRL bit indices.
- One sub-module, fade_interval_timer: load/decrement counter of width INTERVAL_W with an expire output. Treats a load of 0 as 1.

Test Plan:
- Reset mid-WAIT → busy=0, done=0, cur_duty=0, pwm_cs_n=1 immediately (asynchronous); the next start behaves as from reset.
- cur=0, TARGET=10, STEP=4, INTERVAL=3, start → exactly 3 strobes with data 4, 8, 10, spaced 4 clocks apart; then done=1, busy=0, STATUS read=2'b10.
- cur=200, TARGET=5, STEP=0, INTERVAL=0, start → single strobe with data 5 one cycle after WAIT; done=1, no underflow.
- Start with TARGET==cur (e.g. 0) → no PWM strobe; done=1 the cycle after the start write.
- Fade 0→255 with STEP=1, INTERVAL=2; CPU writes 0x200=0x80 on an engine WRITE cycle → forwarded data 0x80 only, engine strobe suppressed, busy=0, done=0, cur_duty=0x80.
- Abort during WAIT at cur=8 → no further strobes, cur_duty stays 8, done=0; re-start with TARGET=12, STEP=4 → one strobe with data 12.
